id_stage: RTL and testbench

//  RV32I decode stage, directly downstream of the fetch stage. Consumes the IF/ID register
//  (PC, instruction, valid); holds the 32x32 register file; generates immediates and control bits.

---
 rtl/id_stage.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage.
// Consumes the IF/ID register, holds the 32x32 register file, generates the
// immediate and control bits, detects load-use hazards and drives the
// registered ID/EX pipeline register (one cycle of latency).
//
// Build option: define ID_WB_BYPASS_EN for a write-first register file
// (a read of the register being written back this cycle returns
// WB_write_data). Without it a read returns the previously stored value.
//
// Flow control: IF_ID_enable_out qualifies the IF/ID payload. This stage
// accepts it on a posedge unless EX_clear_ID_EX, combined_stall or
// ID_load_use_stall is active. ID_load_use_stall is this stage's "not ready"
// towards fetch, which must then hold IF/ID unchanged. ID_EX_enable_out
// qualifies the ID/EX payload for exactly the cycle it is high.

module id_stage #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            combined_stall,
    input  logic            EX_clear_ID_EX,
    input  logic [XLEN-1:0] IF_ID_PC,
    input  logic [31:0]     IF_ID_Instruction,
    input  logic            IF_ID_enable_out,
    input  logic            WB_reg_write,
    input  logic [4:0]      WB_rd,
    input  logic [XLEN-1:0] WB_write_data,
    output logic            ID_load_use_stall,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [6:0]      ID_EX_opcode,
    output logic [2:0]      ID_EX_funct3,
    output logic            ID_EX_funct7_b5,
    output logic            ID_EX_RegWrite,
    output logic            ID_EX_MemRead,
    output logic            ID_EX_MemWrite,
    output logic            ID_EX_MemToReg,
    output logic            ID_EX_ALUSrc,
    output logic            ID_EX_Branch,
    output logic            ID_EX_Jump,
    output logic            ID_EX_illegal,
    output logic            ID_EX_enable_out
);

    // RV32I base opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Control bundle carried through the ID/EX register
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

    // Instruction fields
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_b5;

    // Immediate candidates, all sign-extended from inst[31]
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    // Decode results
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            rs1_used;
    logic            rs2_used;

    // Register file and read ports
    logic [XLEN-1:0] regs [REG_NUM];
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // ID/EX control register
    ctrl_t           ex_ctrl;

    assign opcode    = IF_ID_Instruction[6:0];
    assign rd        = IF_ID_Instruction[11:7];
    assign funct3    = IF_ID_Instruction[14:12];
    assign rs1       = IF_ID_Instruction[19:15];
    assign rs2       = IF_ID_Instruction[24:20];
    assign funct7_b5 = IF_ID_Instruction[30];

    assign imm_i = {{20{IF_ID_Instruction[31]}}, IF_ID_Instruction[31:20]};
    assign imm_s = {{20{IF_ID_Instruction[31]}}, IF_ID_Instruction[31:25],
                    IF_ID_Instruction[11:7]};
    assign imm_b = {{19{IF_ID_Instruction[31]}}, IF_ID_Instruction[31],
                    IF_ID_Instruction[7], IF_ID_Instruction[30:25],
                    IF_ID_Instruction[11:8], 1'b0};
    assign imm_u = {IF_ID_Instruction[31:12], 12'b0};
    assign imm_j = {{11{IF_ID_Instruction[31]}}, IF_ID_Instruction[31],
                    IF_ID_Instruction[19:12], IF_ID_Instruction[20],
                    IF_ID_Instruction[30:21], 1'b0};

    // Opcode decode: control bits, immediate format and source-register usage
    always_comb begin
        dec_ctrl = '0;
        dec_imm  = '0;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_imm            = imm_u;
                rs1_used           = 1'b0;
            end
            OP_JAL: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_imm            = imm_j;
                rs1_used           = 1'b0;
            end
            OP_JALR: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_imm            = imm_i;
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_imm         = imm_b;
                rs2_used        = 1'b1;
            end
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_imm             = imm_i;
            end
            OP_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_imm            = imm_s;
                rs2_used           = 1'b1;
            end
            OP_IMM: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_imm            = imm_i;
            end
            OP_OP: begin
                // R-type: immediate stays 0
                dec_ctrl.reg_write = 1'b1;
                rs2_used           = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                // Legal but no register write or memory side effect here
                dec_ctrl.alu_src = 1'b1;
                dec_imm          = imm_i;
            end
            default: begin
                // Unknown opcode: flagged, never treated as a source reader
                dec_ctrl.illegal = 1'b1;
                rs1_used         = 1'b0;
            end
        endcase
    end

    // Register file write; not gated by stall or flush so write-back never drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_reg_write && (WB_rd != 5'd0)) begin
            regs[WB_rd] <= WB_write_data;
        end
    end

    // Combinational read ports; x0 always reads 0
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0) begin
            rs1_data = regs[rs1];
`ifdef ID_WB_BYPASS_EN
            if (WB_reg_write && (WB_rd == rs1)) begin
                rs1_data = WB_write_data;
            end
`endif
        end
        if (rs2 != 5'd0) begin
            rs2_data = regs[rs2];
`ifdef ID_WB_BYPASS_EN
            if (WB_reg_write && (WB_rd == rs2)) begin
                rs2_data = WB_write_data;
            end
`endif
        end
    end

    // Load-use hazard: a load in EX whose destination is read by the instruction in ID
    assign ID_load_use_stall = IF_ID_enable_out && ID_EX_enable_out && ex_ctrl.mem_read &&
                               (ID_EX_rd != 5'd0) &&
                               ((rs1_used && (rs1 == ID_EX_rd)) ||
                                (rs2_used && (rs2 == ID_EX_rd)));

    // ID/EX pipeline register: flush > stall (hold) > load-use bubble > capture > idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ID_EX_PC         <= '0;
            ID_EX_rs1_data   <= '0;
            ID_EX_rs2_data   <= '0;
            ID_EX_imm        <= '0;
            ID_EX_rs1        <= '0;
            ID_EX_rs2        <= '0;
            ID_EX_rd         <= '0;
            ID_EX_opcode     <= '0;
            ID_EX_funct3     <= '0;
            ID_EX_funct7_b5  <= 1'b0;
            ex_ctrl          <= '0;
            ID_EX_enable_out <= 1'b0;
        end else if (EX_clear_ID_EX) begin
            ex_ctrl          <= '0;
            ID_EX_enable_out <= 1'b0;
        end else if (combined_stall) begin
            // Payload (including control) held; only the valid drops
            ID_EX_enable_out <= 1'b0;
        end else if (ID_load_use_stall) begin
            ex_ctrl          <= '0;
            ID_EX_enable_out <= 1'b0;
        end else if (IF_ID_enable_out) begin
            ID_EX_PC         <= IF_ID_PC;
            ID_EX_rs1_data   <= rs1_data;
            ID_EX_rs2_data   <= rs2_data;
            ID_EX_imm        <= dec_imm;
            ID_EX_rs1        <= rs1;
            ID_EX_rs2        <= rs2;
            ID_EX_rd         <= rd;
            ID_EX_opcode     <= opcode;
            ID_EX_funct3     <= funct3;
            ID_EX_funct7_b5  <= funct7_b5;
            ex_ctrl          <= dec_ctrl;
            ID_EX_enable_out <= 1'b1;
        end else begin
            ex_ctrl          <= '0;
            ID_EX_enable_out <= 1'b0;
        end
    end

    assign ID_EX_RegWrite = ex_ctrl.reg_write;
    assign ID_EX_MemRead  = ex_ctrl.mem_read;
    assign ID_EX_MemWrite = ex_ctrl.mem_write;
    assign ID_EX_MemToReg = ex_ctrl.mem_to_reg;
    assign ID_EX_ALUSrc   = ex_ctrl.alu_src;
    assign ID_EX_Branch   = ex_ctrl.branch;
    assign ID_EX_Jump     = ex_ctrl.jump;
    assign ID_EX_illegal  = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage with an expected-result queue.
// Honours ID_WB_BYPASS_EN for the same-cycle write-back read check.

module tb_id_stage;

    localparam int W = 152;

    // Observation vector layout:
    // [151] enable [150] illegal [149] RegWrite [148] MemRead [147] MemWrite
    // [146] MemToReg [145] ALUSrc [144] Branch [143] Jump [142:138] rd
    // [137:133] rs1 [132:128] rs2 [127:96] imm [95:64] rs1_data
    // [63:32] rs2_data [31:0] PC
    localparam logic [W-1:0] M_ALL  = {W{1'b1}};
    localparam logic [W-1:0] M_CTL  = {9'h1FF, 143'd0};
    localparam logic [W-1:0] M_ILLC = {9'b111110011, 143'd0};
    localparam logic [W-1:0] M_RD   = {9'd0, 5'h1F, 138'd0};
    localparam logic [W-1:0] M_IMM  = {24'd0, 32'hFFFF_FFFF, 96'd0};
    localparam logic [W-1:0] M_D1   = {56'd0, 32'hFFFF_FFFF, 64'd0};
    localparam logic [W-1:0] M_D2   = {88'd0, 32'hFFFF_FFFF, 32'd0};
    localparam logic [W-1:0] M_HOLD = {1'b1, 8'd0, {143{1'b1}}};
    localparam logic [W-1:0] M_EN   = {1'b1, 151'd0};

    // Control patterns: en ill rw mr mw mtr as br jp
    localparam logic [8:0] C_IDLE = 9'b000000000;
    localparam logic [8:0] C_ADDI = 9'b101000100;
    localparam logic [8:0] C_LW   = 9'b101101100;
    localparam logic [8:0] C_ADD  = 9'b101000000;
    localparam logic [8:0] C_BEQ  = 9'b100000010;
    localparam logic [8:0] C_JAL  = 9'b101000101;
    localparam logic [8:0] C_SW   = 9'b100010100;
    localparam logic [8:0] C_LUI  = 9'b101000100;
    localparam logic [8:0] C_ILL  = 9'b110000000;

    // Clock / reset
    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    // DUT signals
    logic        combined_stall;
    logic        EX_clear_ID_EX;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_enable_out;
    logic        WB_reg_write;
    logic [4:0]  WB_rd;
    logic [31:0] WB_write_data;
    logic        ID_load_use_stall;
    logic [31:0] ID_EX_PC, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [6:0]  ID_EX_opcode;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_funct7_b5;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg;
    logic        ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump, ID_EX_illegal, ID_EX_enable_out;

    id_stage dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .combined_stall    (combined_stall),
        .EX_clear_ID_EX    (EX_clear_ID_EX),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_enable_out  (IF_ID_enable_out),
        .WB_reg_write      (WB_reg_write),
        .WB_rd             (WB_rd),
        .WB_write_data     (WB_write_data),
        .ID_load_use_stall (ID_load_use_stall),
        .ID_EX_PC          (ID_EX_PC),
        .ID_EX_rs1_data    (ID_EX_rs1_data),
        .ID_EX_rs2_data    (ID_EX_rs2_data),
        .ID_EX_imm         (ID_EX_imm),
        .ID_EX_rs1         (ID_EX_rs1),
        .ID_EX_rs2         (ID_EX_rs2),
        .ID_EX_rd          (ID_EX_rd),
        .ID_EX_opcode      (ID_EX_opcode),
        .ID_EX_funct3      (ID_EX_funct3),
        .ID_EX_funct7_b5   (ID_EX_funct7_b5),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_MemWrite    (ID_EX_MemWrite),
        .ID_EX_MemToReg    (ID_EX_MemToReg),
        .ID_EX_ALUSrc      (ID_EX_ALUSrc),
        .ID_EX_Branch      (ID_EX_Branch),
        .ID_EX_Jump        (ID_EX_Jump),
        .ID_EX_illegal     (ID_EX_illegal),
        .ID_EX_enable_out  (ID_EX_enable_out)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        tag_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic logic [W-1:0] mk(input logic [8:0] c, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] pc);
        return {c, rd, rs1, rs2, imm, d1, d2, pc};
    endfunction

    function automatic logic [W-1:0] observe();
        return {ID_EX_enable_out, ID_EX_illegal, ID_EX_RegWrite, ID_EX_MemRead,
                ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump,
                ID_EX_rd, ID_EX_rs1, ID_EX_rs2, ID_EX_imm, ID_EX_rs1_data,
                ID_EX_rs2_data, ID_EX_PC};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp, input logic [W-1:0] mask);
        n_cmp++;
        assert ((obs & mask) === (exp & mask)) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs & mask, exp & mask);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp);
        n_cmp++;
        assert (ID_load_use_stall === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, ID_load_use_stall, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] exp,
                              input logic [W-1:0] mask);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        mask_q.push_back(mask);
    endtask

    // Advance one clock, then compare every pending expectation
    task automatic tick();
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            check(tag_q.pop_front(), observe(), exp_q.pop_front(), mask_q.pop_front());
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic valid);
        IF_ID_PC          = pc;
        IF_ID_Instruction = inst;
        IF_ID_enable_out  = valid;
    endtask

    task automatic wb_set(input logic en, input logic [4:0] rd, input logic [31:0] data);
        WB_reg_write  = en;
        WB_rd         = rd;
        WB_write_data = data;
    endtask

    // Write-back only cycle, with an empty IF/ID
    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_set(1'b1, rd, data);
        drive(32'h0, 32'h0, 1'b0);
        expect_out("idle_wb", mk(C_IDLE, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        tick();
        wb_set(1'b0, 5'd0, 32'h0);
    endtask

    logic [31:0] exp_x9;

    initial begin
        reset_n        = 1'b0;
        combined_stall = 1'b0;
        EX_clear_ID_EX = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        wb_set(1'b0, 5'd0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outputs", observe(), '0, M_ALL);
        check_stall("reset_stall", 1'b0);
        reset_n = 1'b1;

        // Write-back then dependent addi x6,x5,1
        wb_write(5'd5, 32'hDEAD_BEEF);
        wb_write(5'd2, 32'h0000_0022);
        drive(32'h100, 32'h0012_8313, 1'b1);
        expect_out("addi_decode",
                   mk(C_ADDI, 5'd6, 5'd5, 5'd1, 32'd1, 32'hDEAD_BEEF, 32'd0, 32'h100), M_ALL);
        tick();
        check("addi_opcode", W'(ID_EX_opcode), W'(7'h13), M_ALL);

        // lw x7,0(x1) followed by add x8,x7,x2
        drive(32'h104, 32'h0000_A383, 1'b1);
        #1;
        check_stall("lw_no_stall", 1'b0);
        expect_out("lw_decode",
                   mk(C_LW, 5'd7, 5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 32'h104), M_ALL);
        tick();
        drive(32'h108, 32'h0023_8433, 1'b1);
        #1;
        check_stall("loaduse_on", 1'b1);
        expect_out("loaduse_bubble", mk(C_IDLE, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        tick();
        check_stall("loaduse_off", 1'b0);
        expect_out("add_after_bubble",
                   mk(C_ADD, 5'd8, 5'd7, 5'd2, 32'd0, 32'd0, 32'h22, 32'h108), M_ALL);
        tick();

        // beq x0,x0,-4, then the same with a flush from EX
        drive(32'h200, 32'hFE00_0EE3, 1'b1);
        expect_out("beq_decode",
                   mk(C_BEQ, 5'd29, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h200), M_ALL);
        tick();
        drive(32'h204, 32'hFE00_0EE3, 1'b1);
        EX_clear_ID_EX = 1'b1;
        expect_out("beq_flushed", mk(C_IDLE, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        tick();
        EX_clear_ID_EX = 1'b0;

        // Global stall for 3 cycles holds the captured addi payload
        drive(32'h300, 32'h0012_8313, 1'b1);
        expect_out("addi_pre_stall",
                   mk(C_ADDI, 5'd6, 5'd5, 5'd1, 32'd1, 32'hDEAD_BEEF, 32'd0, 32'h300), M_ALL);
        tick();
        drive(32'h304, 32'h0000_A383, 1'b1);
        combined_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("stall_hold_%0d", i),
                       mk(C_IDLE, 5'd6, 5'd5, 5'd1, 32'd1, 32'hDEAD_BEEF, 32'd0, 32'h300),
                       M_HOLD);
            tick();
        end
        combined_stall = 1'b0;
        expect_out("stall_release",
                   mk(C_LW, 5'd7, 5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 32'h304), M_ALL);
        tick();

        // Other immediate formats
        drive(32'h400, 32'h0080_00EF, 1'b1);
        expect_out("jal_decode", mk(C_JAL, 5'd1, 0, 0, 32'd8, 0, 0, 0), M_CTL | M_IMM | M_RD);
        tick();
        drive(32'h404, 32'h0020_A223, 1'b1);
        expect_out("sw_decode", mk(C_SW, 0, 0, 0, 32'd4, 0, 32'h22, 0), M_CTL | M_IMM | M_D2);
        tick();
        drive(32'h408, 32'h1234_5537, 1'b1);
        expect_out("lui_decode", mk(C_LUI, 5'd10, 0, 0, 32'h1234_5000, 0, 0, 0),
                   M_CTL | M_IMM | M_RD);
        tick();

        // Same-cycle write-back read of x9
        wb_write(5'd9, 32'h0000_1111);
`ifdef ID_WB_BYPASS_EN
        exp_x9 = 32'h0000_1234;
`else
        exp_x9 = 32'h0000_1111;
`endif
        wb_set(1'b1, 5'd9, 32'h0000_1234);
        drive(32'h500, 32'h0004_8513, 1'b1);
        expect_out("wb_same_cycle", mk(C_ADDI, 0, 0, 0, 0, exp_x9, 0, 0), M_CTL | M_D1);
        tick();
        wb_set(1'b0, 5'd0, 32'h0);
        drive(32'h504, 32'h0004_8513, 1'b1);
        expect_out("wb_next_cycle", mk(C_ADDI, 0, 0, 0, 0, 32'h1234, 0, 0), M_CTL | M_D1);
        tick();

        // Write-back to x0 is ignored
        wb_set(1'b1, 5'd0, 32'hFFFF_FFFF);
        drive(32'h508, 32'h0000_0513, 1'b1);
        expect_out("x0_same_cycle", mk(C_ADDI, 0, 0, 0, 0, 0, 0, 0), M_CTL | M_D1);
        tick();
        wb_set(1'b0, 5'd0, 32'h0);
        drive(32'h50C, 32'h0000_0513, 1'b1);
        expect_out("x0_after_write", mk(C_ADDI, 0, 0, 0, 0, 0, 0, 0), M_CTL | M_D1);
        tick();

        // Illegal opcode
        drive(32'h510, 32'h0000_007F, 1'b1);
        expect_out("illegal_decode", mk(C_ILL, 0, 0, 0, 0, 0, 0, 0), M_ILLC);
        tick();
        check("illegal_opcode_field", W'(ID_EX_opcode), W'(7'h7F), M_ALL);

        // Asynchronous reset mid-cycle clears everything at once
        drive(32'h514, 32'h0012_8313, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun_reset", observe(), '0, M_ALL);
        check("midrun_reset_op", W'({ID_EX_opcode, ID_EX_funct3, ID_EX_funct7_b5}), '0, M_ALL);
        #2;
        reset_n = 1'b1;
        drive(32'h0, 32'h0, 1'b0);
        tick();

        // Every register x1..x31 reads 0 after reset (x2, x5, x9 were non-zero)
        for (int k = 1; k < 32; k++) begin
            drive(32'h600 + 32'(4 * k), (32'(k) << 20) | (32'(k) << 15) | 32'h33, 1'b1);
            expect_out($sformatf("cleared_x%0d", k), mk(C_ADD, 0, 0, 0, 0, 0, 0, 0),
                       M_EN | M_D1 | M_D2);
            tick();
        end
        drive(32'h0, 32'h0, 1'b0);
        expect_out("final_idle", mk(C_IDLE, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
